// File: rtl/pong_pkg.sv
// pong_pkg: state, result-code and score definitions shared by the pong ball, controller and renderer blocks
package pong_pkg;
  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;
  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_P1   = 2'd1;
  localparam logic [1:0] RES_P2   = 2'd2;
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction
endpackage

// File: rtl/pong_serve_timer.sv
// pong_serve_timer: 32-bit serve-delay counter; clr zeroes it, en advances it, done flags count==SERVE_DELAY-1
// Ports: i_Clk, i_Reset (async, active-high), clr, en, done
module pong_serve_timer #(
  parameter logic [31:0] SERVE_DELAY = 32'd25_000_000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic clr,
  input  logic en,
  output logic done
);
  logic [31:0] count;
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 32'd1;
  assign done = count == SERVE_DELAY - 32'd1;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match controller gating the ball enable, keeping scores and declaring the winner
// Ports: i_Clk, i_Reset (async, active-high), i_start (debounced button), i_game_result (ball result code),
//        o_ball_enable, o_P1_score, o_P2_score, o_state (FSM code), o_winner (0 none, 1 P1, 2 P2)
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [31:0] SERVE_DELAY = 32'd25_000_000,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_start,
  input  logic [1:0]         i_game_result,
  output logic               o_ball_enable,
  output logic [SCORE_W-1:0] o_P1_score,
  output logic [SCORE_W-1:0] o_P2_score,
  output logic [2:0]         o_state,
  output logic [1:0]         o_winner
);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  state_t state;
  logic start_q, start_rise, serve_done, p1_win, p2_win, timer_clr;
  assign start_rise = i_start & ~start_q;
  assign p1_win = o_P1_score >= WIN;
  assign p2_win = o_P2_score >= WIN;
  assign o_state = state;
  // The counter restarts on every way into SERVE and only runs while serving
  assign timer_clr = ((state == ST_IDLE || state == ST_GAME_OVER) && start_rise) ||
                     (state == ST_POINT && !(p1_win || p2_win));
  pong_serve_timer #(.SERVE_DELAY(SERVE_DELAY)) u_timer (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .clr    (timer_clr),
    .en     (state == ST_SERVE),
    .done   (serve_done)
  );
  always_ff @(posedge i_Clk or posedge i_Reset)
    if (i_Reset) begin
      state         <= ST_IDLE;
      start_q       <= 1'b0;
      o_ball_enable <= 1'b0;
      o_P1_score    <= '0;
      o_P2_score    <= '0;
      o_winner      <= 2'd0;
    end else begin
      start_q <= i_start;
      case (state)
        ST_IDLE: begin
          o_ball_enable <= 1'b0;
          if (start_rise) state <= ST_SERVE;
        end
        ST_SERVE:
          if (serve_done) begin
            state         <= ST_PLAY;
            o_ball_enable <= 1'b1;
          end
        ST_PLAY:
          if (i_game_result == RES_P1) begin
            o_P1_score    <= sat_inc(o_P1_score);
            state         <= ST_POINT;
            o_ball_enable <= 1'b0;
          end else if (i_game_result == RES_P2) begin
            o_P2_score    <= sat_inc(o_P2_score);
            state         <= ST_POINT;
            o_ball_enable <= 1'b0;
          end
        ST_POINT:
          if (p1_win || p2_win) begin
            state    <= ST_GAME_OVER;
            o_winner <= p1_win ? 2'd1 : 2'd2;
          end else state <= ST_SERVE;
        ST_GAME_OVER:
          if (start_rise) begin
            state      <= ST_SERVE;
            o_P1_score <= '0;
            o_P2_score <= '0;
            o_winner   <= 2'd0;
          end
        default: begin
          state         <= ST_IDLE;
          o_ball_enable <= 1'b0;
        end
      endcase
    end
endmodule
